// File: rtl/rx_port_arbiter.sv
// rx_port_arbiter
// Collects words from NPORTS receivers into per-port FIFOs and drains them
// round-robin, one word per grant, into a single valid/ready output register.
// A full FIFO drops an incoming word and flags it with a one-cycle pulse.

module rx_port_arbiter #(
  parameter int WIDTH  = 32,
  parameter int NPORTS = 4,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NPORTS*WIDTH-1:0]     rx_data,
  input  logic [NPORTS-1:0]           rx_alert,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(NPORTS)-1:0]   out_port,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NPORTS-1:0]           full,
  output logic [NPORTS-1:0]           drop_pulse
);

  localparam int PW = $clog2(NPORTS);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0]  w_head [NPORTS];
  logic [NPORTS-1:0] w_wr;
  logic [NPORTS-1:0] w_pop;
  logic [NPORTS-1:0] w_nonempty;
  logic [NPORTS-1:0] w_full;
  logic [NPORTS-1:0] w_drop;

  logic              w_load;
  logic              w_found;
  logic [PW-1:0]     w_idx;
  int                w_cand;

  logic [WIDTH-1:0]  r_out_data;
  logic [PW-1:0]     r_out_port;
  logic              r_out_valid;
  logic [PW-1:0]     r_last_grant;

  // The output register may take a new word when it is empty or its word leaves now.
  assign w_load = ~r_out_valid | out_ready;

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_full;
    logic             r_drop;

    // The full check uses the registered flag, so a pop in the same cycle does not save the word.
    assign w_wr[gi]       = rx_alert[gi] & ~r_full;
    assign w_pop[gi]      = w_load & w_found & (w_idx == PW'(gi));
    assign w_head[gi]     = r_mem[r_rptr];
    assign w_nonempty[gi] = (r_cnt != CW'(0));
    assign w_full[gi]     = r_full;
    assign w_drop[gi]     = r_drop;

    // Next occupancy: a simultaneous write and pop leaves the count unchanged.
    always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_wr[gi], w_pop[gi]})
        2'b10:   w_cnt_nxt = r_cnt + CW'(1);
        2'b01:   w_cnt_nxt = r_cnt - CW'(1);
        default: w_cnt_nxt = r_cnt;
      endcase
    end

    // Word storage, written at the tail pointer.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d < DEPTH; d++) begin
          r_mem[d] <= '0;
        end
      end else if (w_wr[gi]) begin
        r_mem[r_wptr] <= rx_data[gi*WIDTH +: WIDTH];
      end
    end

    // Pointers (wrap modulo DEPTH), count, full flag and drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
        r_full <= 1'b0;
        r_drop <= 1'b0;
      end else begin
        if (w_wr[gi]) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_pop[gi]) begin
          r_rptr <= r_rptr + AW'(1);
        end
        r_cnt  <= w_cnt_nxt;
        r_full <= (w_cnt_nxt == CW'(DEPTH));
        r_drop <= rx_alert[gi] & r_full;
      end
    end
  end

  // Round-robin search starting just after the last granted port.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = 0;
    for (int k = 1; k <= NPORTS; k++) begin
      w_cand = (int'(r_last_grant) + k) % NPORTS;
      if (!w_found && w_nonempty[w_cand]) begin
        w_found = 1'b1;
        w_idx   = PW'(w_cand);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Output register: load the granted head, or go idle when nothing is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data   <= '0;
      r_out_port   <= '0;
      r_out_valid  <= 1'b0;
      r_last_grant <= PW'(NPORTS - 1);
    end else if (w_load) begin
      if (w_found) begin
        r_out_data   <= w_head[w_idx];
        r_out_port   <= w_idx;
        r_out_valid  <= 1'b1;
        r_last_grant <= w_idx;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_port   = r_out_port;
  assign out_valid  = r_out_valid;
  assign full       = w_full;
  assign drop_pulse = w_drop;

endmodule
